// File: rtl/fwrisc_wb_amo_sram.sv
// fwrisc_wb_amo_sram
//
// Wishbone target memory with atomic read-modify-write support. This block
// serves instruction fetches and data accesses from a single synchronous
// single-port RAM. Atomic accesses are tagged on tgc. For these, the old
// word is returned on dat_r and the updated word is committed within the
// same transaction. Every transaction ends with a one-cycle ack or err
// pulse.
//
// Ports:
//   clock  - single clock, rising edge
//   reset  - asynchronous, active-high reset (the RAM itself is not reset)
//   adr    - byte address; adr[ADDR_WIDTH+1:2] selects the word, the
//            upper bits alias
//   dat_w  - write data / AMO operand
//   dat_r  - registered read data (the old value for an AMO)
//   cyc    - bus cycle
//   stb    - strobe; a request is cyc && stb
//   we     - write enable for plain accesses
//   sel    - byte lane enables
//   tgc    - AMO code: 0 none, 1 SWAP, 2 ADD, 3 XOR, 4 AND, 5 OR,
//            6 MIN, 7 MAX, 8 MINU, 9 MAXU
//   ack    - one-cycle completion pulse
//   err    - one-cycle error pulse, issued instead of ack
module fwrisc_wb_amo_sram #(
  parameter int ADDR_WIDTH = 12,
  parameter     INIT_FILE  = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] adr,
  input  logic [31:0] dat_w,
  output logic [31:0] dat_r,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [3:0]  tgc,
  output logic        ack,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    RESP
  } state_t;

  state_t                  state_q;
  logic                    ack_q;
  logic                    err_q;
  logic [31:0]             datR_q;
  logic [ADDR_WIDTH-1:0]   wordIdx_q;
  logic [3:0]              op_q;
  logic [31:0]             operand_q;
  logic [31:0]             rdata_q;

  logic [31:0]             mem [0:DEPTH-1];

  logic                    req;
  logic [ADDR_WIDTH-1:0]   reqIdx;
  logic                    isAmoCode;
  logic                    amoLegal;
  logic [31:0]             amoResult;

  logic                    memWe;
  logic                    memRe;
  logic [3:0]              memBe;
  logic [ADDR_WIDTH-1:0]   memIdx;
  logic [31:0]             memWdata;

  logic                    unusedAdrBits;

  assign req       = cyc && stb;
  assign reqIdx    = adr[ADDR_WIDTH+1:2];
  assign isAmoCode = (tgc != 4'd0) && (tgc <= 4'd9);
  // An AMO must be a full, naturally aligned word.
  assign amoLegal  = isAmoCode && (sel == 4'hF) && (adr[1:0] == 2'b00);

  // The upper address bits alias onto the RAM and are intentionally ignored.
  assign unusedAdrBits = ^adr[31:ADDR_WIDTH+2];

  assign dat_r = datR_q;
  assign ack   = ack_q;
  assign err   = err_q;

  // New word for an AMO, computed from the RAM word read in RD and the
  // operand captured when the request was accepted.
  always_comb begin
    amoResult = rdata_q;
    case (op_q)
      4'd1: amoResult = operand_q;
      4'd2: amoResult = rdata_q + operand_q;
      4'd3: amoResult = rdata_q ^ operand_q;
      4'd4: amoResult = rdata_q & operand_q;
      4'd5: amoResult = rdata_q | operand_q;
      4'd6: amoResult = ($signed(rdata_q) < $signed(operand_q)) ? rdata_q : operand_q;
      4'd7: amoResult = ($signed(rdata_q) > $signed(operand_q)) ? rdata_q : operand_q;
      4'd8: amoResult = (rdata_q < operand_q) ? rdata_q : operand_q;
      4'd9: amoResult = (rdata_q > operand_q) ? rdata_q : operand_q;
      default: amoResult = rdata_q;
    endcase
  end

  // RAM port control. In IDLE, the port serves a plain write, or it issues
  // the read for a plain read or a legal AMO. In RD, the port commits the
  // AMO result, unless the initiator has aborted. The write enable is gated
  // by reset, so an AMO caught by reset never lands.
  always_comb begin
    memWe    = 1'b0;
    memRe    = 1'b0;
    memBe    = 4'h0;
    memIdx   = reqIdx;
    memWdata = dat_w;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (tgc == 4'd0) begin
            if (we) begin
              memWe = 1'b1;
              memBe = sel;
            end else begin
              memRe = 1'b1;
            end
          end else if (amoLegal) begin
            memRe = 1'b1;
          end
        end
      end
      RD: begin
        if (req && (op_q != 4'd0)) begin
          memWe    = 1'b1;
          memBe    = 4'hF;
          memIdx   = wordIdx_q;
          memWdata = amoResult;
        end
      end
      default: ;
    endcase
    memWe = memWe && !reset;
  end

  // Synchronous single-port RAM with byte-lane writes. It has no reset.
  always_ff @(posedge clock) begin
    if (memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (memBe[b]) begin
          mem[memIdx][8*b +: 8] <= memWdata[8*b +: 8];
        end
      end
    end
    if (memRe) begin
      rdata_q <= mem[memIdx];
    end
  end

  // Transaction FSM with registered ack/err/dat_r. The FSM accepts requests
  // only in IDLE. RESP always lasts exactly one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      datR_q    <= 32'h0;
      wordIdx_q <= '0;
      op_q      <= 4'd0;
      operand_q <= 32'h0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            wordIdx_q <= reqIdx;
            op_q      <= tgc;
            operand_q <= dat_w;
            if (tgc == 4'd0) begin
              if (we) begin
                ack_q   <= 1'b1;
                state_q <= RESP;
              end else begin
                state_q <= RD;
              end
            end else if (amoLegal) begin
              state_q <= RD;
            end else begin
              err_q   <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        RD: begin
          if (req) begin
            datR_q  <= rdata_q;
            ack_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            state_q <= IDLE;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
